// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg
//   Shared definitions for the APB slave bridge:
//   - state_t      : bridge FSM states
//   - in_window()  : constant-usable address window check, evaluated one bit
//                    wider than any supported address so a window ending at
//                    the top of the address space does not wrap
//   - APB_BRIDGE_ASSERT : elaboration-time parameter legality check
`define APB_BRIDGE_ASSERT(cond, label, msg) \
  if (!(cond)) begin : label \
    $error(msg); \
  end

package apb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    DONE,
    ERR
  } state_t;

  // Widest supported address; window math is done on MAX_AW+1 bits.
  localparam int MAX_AW = 64;
  localparam int EXT_W  = MAX_AW + 1;

  function automatic logic in_window(input logic [EXT_W-1:0] addr,
                                     input logic [EXT_W-1:0] base,
                                     input logic [EXT_W-1:0] span);
    return (addr >= base) && (addr < (base + span));
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt
//   Backend watchdog. Counts cycles while enable is high; expired is raised
//   during the cycle in which the count reaches TIMEOUT_CYCLES, so the owner
//   can act on the edge that ends that cycle. TIMEOUT_CYCLES = 0 disables
//   the watchdog (expired never asserts).
// Ports:
//   clk     in  clock
//   rstn    in  asynchronous active-low reset
//   clear   in  restart the count at zero
//   enable  in  count this cycle
//   expired out limit reached
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] count_reg;

  // Count value k means k full cycles have already elapsed; the cycle in
  // which count == LAST is therefore the TIMEOUT_CYCLES-th one.
  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count_reg == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/apb_slave_bridge.sv
// apb_slave_bridge
//   APB3/APB4 slave that turns each in-window transfer into a registered
//   valid/ready request toward a backend, waits for the backend response and
//   completes the APB access. Out-of-window accesses complete with PSLVERR
//   and never reach the backend. A watchdog bounds the backend wait.
// Ports:
//   i_clk_apb, i_rstn_apb            clock, async active-low reset
//   i_psel .. i_pprot                APB request
//   o_prdata, o_pready, o_pslverr    APB completion
//   o_valid, i_ready                 backend request handshake
//   o_addr, o_rd0_wr1, o_wr_data,
//   o_wr_strb, o_prot                backend request fields (window offset)
//   i_rsp_valid, i_rd_data, i_rsp_err backend response
module apb_slave_bridge
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN = 32'h0000_1000,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  i_clk_apb,
  input  logic                  i_rstn_apb,
  input  logic                  i_psel,
  input  logic                  i_penable,
  input  logic                  i_pwrite,
  input  logic [ADDR_WIDTH-1:0] i_paddr,
  input  logic [DATA_WIDTH-1:0] i_pwdata,
  input  logic [STRB_WIDTH-1:0] i_pstrb,
  input  logic [2:0]            i_pprot,
  output logic [DATA_WIDTH-1:0] o_prdata,
  output logic                  o_pready,
  output logic                  o_pslverr,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_rd0_wr1,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic [STRB_WIDTH-1:0] o_wr_strb,
  output logic [2:0]            o_prot,
  input  logic                  i_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_rsp_err
);

  `APB_BRIDGE_ASSERT((DATA_WIDTH == 8) || (DATA_WIDTH == 16) || (DATA_WIDTH == 32) || (DATA_WIDTH == 64),
                     g_bad_data_width, "apb_slave_bridge: DATA_WIDTH must be 8, 16, 32 or 64")
  `APB_BRIDGE_ASSERT((ADDR_WIDTH >= 1) && (ADDR_WIDTH <= MAX_AW),
                     g_bad_addr_width, "apb_slave_bridge: ADDR_WIDTH out of range")
  `APB_BRIDGE_ASSERT((ADDR_SPAN != '0) && ((ADDR_SPAN & (ADDR_SPAN - 1'b1)) == '0),
                     g_bad_span, "apb_slave_bridge: ADDR_SPAN must be a power of two")
  `APB_BRIDGE_ASSERT((BASE_ADDR & (ADDR_SPAN - 1'b1)) == '0,
                     g_bad_base, "apb_slave_bridge: BASE_ADDR must be aligned to ADDR_SPAN")

  state_t state_reg, state_next;

  logic                  valid_reg,   valid_next;
  logic [ADDR_WIDTH-1:0] addr_reg,    addr_next;
  logic                  dir_reg,     dir_next;
  logic [DATA_WIDTH-1:0] wdata_reg,   wdata_next;
  logic [STRB_WIDTH-1:0] strb_reg,    strb_next;
  logic [2:0]            prot_reg,    prot_next;
  logic [DATA_WIDTH-1:0] prdata_reg,  prdata_next;
  logic                  pslverr_reg, pslverr_next;
  // Set once PSEL has been seen low mid-transfer; the backend exchange still
  // finishes but its result is dropped.
  logic                  aborted_reg, aborted_next;

  logic                  cnt_clear;
  logic                  cnt_enable;
  logic                  expired;
  logic                  abort_now;
  logic                  rsp_ok;
  logic                  in_win;
  logic [STRB_WIDTH-1:0] strb_masked;

  assign in_win = in_window(EXT_W'(i_paddr), EXT_W'(BASE_ADDR), EXT_W'(ADDR_SPAN));

  // Reads never carry byte strobes to the backend.
  for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_strb
    assign strb_masked[gi] = i_pwrite & i_pstrb[gi];
  end

  assign cnt_enable = (state_reg == REQ) || (state_reg == WAIT_RSP);

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (i_clk_apb),
    .rstn   (i_rstn_apb),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(expired)
  );

  always_comb begin
    state_next   = state_reg;
    valid_next   = valid_reg;
    addr_next    = addr_reg;
    dir_next     = dir_reg;
    wdata_next   = wdata_reg;
    strb_next    = strb_reg;
    prot_next    = prot_reg;
    prdata_next  = prdata_reg;
    pslverr_next = pslverr_reg;
    aborted_next = aborted_reg;
    cnt_clear    = 1'b0;
    abort_now    = aborted_reg | ~i_psel;
    // A response counts in WAIT_RSP, or in REQ only together with the
    // request handshake.
    rsp_ok       = i_rsp_valid && ((state_reg == WAIT_RSP) || i_ready);

    case (state_reg)
      IDLE: begin
        // PSEL alone starts a transfer, so a missing setup phase
        // (PSEL and PENABLE together) is handled the same way.
        if (i_psel) begin
          if (in_win) begin
            state_next   = REQ;
            valid_next   = 1'b1;
            addr_next    = i_paddr - BASE_ADDR;
            dir_next     = i_pwrite;
            wdata_next   = i_pwdata;
            strb_next    = strb_masked;
            prot_next    = i_pprot;
            aborted_next = 1'b0;
            cnt_clear    = 1'b1;
          end else begin
            state_next   = ERR;
            pslverr_next = 1'b1;
            prdata_next  = '0;
          end
        end
      end

      REQ, WAIT_RSP: begin
        aborted_next = abort_now;
        if (rsp_ok) begin
          valid_next = 1'b0;
          if (abort_now) begin
            state_next = IDLE;
          end else begin
            state_next   = DONE;
            prdata_next  = (!dir_reg && !i_rsp_err) ? i_rd_data : '0;
            pslverr_next = i_rsp_err;
          end
        end else if (expired) begin
          valid_next = 1'b0;
          if (abort_now) begin
            state_next = IDLE;
          end else begin
            state_next   = DONE;
            pslverr_next = 1'b1;
            prdata_next  = '0;
          end
        end else if ((state_reg == REQ) && i_ready) begin
          valid_next = 1'b0;
          state_next = WAIT_RSP;
        end
      end

      DONE, ERR: begin
        // Leave on the completing access, or immediately if PSEL went away.
        if (!i_psel || i_penable) begin
          state_next   = IDLE;
          prdata_next  = '0;
          pslverr_next = 1'b0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
    if (!i_rstn_apb) begin
      state_reg   <= IDLE;
      valid_reg   <= 1'b0;
      addr_reg    <= '0;
      dir_reg     <= 1'b0;
      wdata_reg   <= '0;
      strb_reg    <= '0;
      prot_reg    <= '0;
      prdata_reg  <= '0;
      pslverr_reg <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      valid_reg   <= valid_next;
      addr_reg    <= addr_next;
      dir_reg     <= dir_next;
      wdata_reg   <= wdata_next;
      strb_reg    <= strb_next;
      prot_reg    <= prot_next;
      prdata_reg  <= prdata_next;
      pslverr_reg <= pslverr_next;
      aborted_reg <= aborted_next;
    end
  end

  assign o_pready  = ((state_reg == DONE) || (state_reg == ERR)) && i_psel && i_penable;
  assign o_prdata  = prdata_reg;
  assign o_pslverr = pslverr_reg;
  assign o_valid   = valid_reg;
  assign o_addr    = addr_reg;
  assign o_rd0_wr1 = dir_reg;
  assign o_wr_data = wdata_reg;
  assign o_wr_strb = strb_reg;
  assign o_prot    = prot_reg;

endmodule
